// File: rtl/uart_bram_loader_pkg.sv
// Shared definitions for the UART-to-BRAM frame loader and the port-B reader.
// Holds default geometry and the capture state encoding.
package uart_bram_loader_pkg;

    localparam int DEF_ADDR_W    = 12;
    localparam int DEF_NUM_WORDS = 4096;
    localparam int DEF_TIMEOUT   = 100000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_HI = 2'd1,
        WAIT_LO = 2'd2
    } state_t;

endpackage

// File: rtl/uart_bram_loader_gap_timer.sv
// Inter-byte gap counter: clear, count-enable, and a combinational expire pulse
// asserted on the TIMEOUT-th enabled cycle since the last clear. TIMEOUT=0 never expires.
module gap_timer #(
    parameter int TIMEOUT = 100000
) (
    input  logic clka,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

    logic [CW-1:0] count;

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && count != LAST) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (TIMEOUT > 0) && en && (count == LAST);

endmodule

// File: rtl/uart_bram_loader.sv
// Packs received UART bytes into 16-bit words (high byte first) and writes them to
// sequential BRAM port-A addresses, reporting frame completion or a mid-word timeout.
module uart_bram_loader
    import uart_bram_loader_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int NUM_WORDS = DEF_NUM_WORDS,
    parameter int TIMEOUT   = DEF_TIMEOUT
) (
    input  logic              clka,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [15:0]       dina,
    output logic              busy,
    output logic              done,
    output logic              err_timeout,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [ADDR_W:0]   FULL     = (ADDR_W + 1)'(NUM_WORDS);
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(NUM_WORDS - 1);

    // Handshake: rx_valid is a one-cycle strobe with no back-pressure; every strobe
    // while armed is consumed in the cycle it is presented.
    state_t            state;
    logic [7:0]        hi_byte;
    logic [ADDR_W-1:0] ptr;
    logic              gap_clr;
    logic              gap_en;
    logic              gap_expire;

    assign gap_clr = (state != WAIT_LO);
    assign gap_en  = (state == WAIT_LO) && !rx_valid && !abort;

    gap_timer #(.TIMEOUT(TIMEOUT)) u_gap_timer (
        .clka   (clka),
        .rst_n  (rst_n),
        .clr    (gap_clr),
        .en     (gap_en),
        .expire (gap_expire)
    );

    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hi_byte       <= '0;
            ptr           <= '0;
            wea           <= 1'b0;
            addra         <= '0;
            dina          <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err_timeout   <= 1'b0;
            words_written <= '0;
        end else begin
            wea <= 1'b0;
            // done follows the final write by one cycle; a start in that cycle still clears it
            if (wea && words_written == FULL) begin
                done <= 1'b1;
            end
            if (abort) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state         <= WAIT_HI;
                            busy          <= 1'b1;
                            ptr           <= '0;
                            words_written <= '0;
                            done          <= 1'b0;
                            err_timeout   <= 1'b0;
                        end
                    end
                    WAIT_HI: begin
                        if (rx_valid) begin
                            hi_byte <= rx_data;
                            state   <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (rx_valid) begin
                            wea           <= 1'b1;
                            addra         <= ptr;
                            dina          <= {hi_byte, rx_data};
                            words_written <= words_written + 1'b1;
                            if (ptr == PTR_LAST) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                ptr   <= ptr + 1'b1;
                                state <= WAIT_HI;
                            end
                        end else if (gap_expire) begin
                            state       <= IDLE;
                            busy        <= 1'b0;
                            err_timeout <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_bram_loader.sv
// Directed bench for uart_bram_loader: a 4-word frame buffer with a 50-cycle
// timeout, plus a 2-bit-address instance with the timeout disabled.
module tb_uart_bram_loader;

    logic        clka;
    logic        rst_n;
    logic        start, abort, rx_valid;
    logic [7:0]  rx_data;
    logic        wea, busy, done, err_timeout;
    logic [11:0] addra;
    logic [15:0] dina;
    logic [12:0] words_written;

    logic        s_start, s_abort, s_rx_valid;
    logic [7:0]  s_rx_data;
    logic        s_wea, s_busy, s_done, s_err_timeout;
    logic [1:0]  s_addra;
    logic [15:0] s_dina;
    logic [2:0]  s_words_written;

    int total = 0;
    int bad   = 0;
    int rise;

    logic [27:0] exp_q[$];
    logic [17:0] s_exp_q[$];
    logic [15:0] mem [4];
    logic        prev_wea = 1'b0;

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        int          gap;
        logic [11:0] exp_addr;
        logic [15:0] exp_data;
    } vec_t;
    vec_t vecs [8];

    uart_bram_loader #(.ADDR_W(12), .NUM_WORDS(4), .TIMEOUT(50)) dut (
        .clka          (clka),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .wea           (wea),
        .addra         (addra),
        .dina          (dina),
        .busy          (busy),
        .done          (done),
        .err_timeout   (err_timeout),
        .words_written (words_written)
    );

    uart_bram_loader #(.ADDR_W(2), .NUM_WORDS(4), .TIMEOUT(0)) dut_small (
        .clka          (clka),
        .rst_n         (rst_n),
        .start         (s_start),
        .abort         (s_abort),
        .rx_data       (s_rx_data),
        .rx_valid      (s_rx_valid),
        .wea           (s_wea),
        .addra         (s_addra),
        .dina          (s_dina),
        .busy          (s_busy),
        .done          (s_done),
        .err_timeout   (s_err_timeout),
        .words_written (s_words_written)
    );

    // clock / watchdog
    initial clka = 1'b0;
    always #5 clka = ~clka;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // drivers: callers sit 1 time unit after a rising edge
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clka);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data  = b;
        rx_valid = 1'b1;
        step(1);
        rx_valid = 1'b0;
        step(gap);
    endtask

    task automatic s_send_byte(input logic [7:0] b, input int gap);
        s_rx_data  = b;
        s_rx_valid = 1'b1;
        step(1);
        s_rx_valid = 1'b0;
        step(gap);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        step(1);
        abort = 1'b0;
    endtask

    task automatic run_rows(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            exp_q.push_back({vecs[i].exp_addr, vecs[i].exp_data});
            send_byte(vecs[i].hi, vecs[i].gap);
            send_byte(vecs[i].lo, vecs[i].gap);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_wea"},   {31'd0, wea}, 32'd0);
        check({tag, "_addra"}, {20'd0, addra}, 32'd0);
        check({tag, "_dina"},  {16'd0, dina}, 32'd0);
        check({tag, "_busy"},  {31'd0, busy}, 32'd0);
        check({tag, "_done"},  {31'd0, done}, 32'd0);
        check({tag, "_err"},   {31'd0, err_timeout}, 32'd0);
        check({tag, "_words"}, {19'd0, words_written}, 32'd0);
    endtask

    task automatic readback(input int first);
        for (int i = 0; i < 4; i++) begin
            check("readback", {16'd0, mem[i]}, {16'd0, vecs[first + i].exp_data});
        end
    endtask

    // scoreboard: every port-A write must match the head of the expected queue
    always @(negedge clka) begin : main_mon
        logic [27:0] e;
        if (wea) begin
            check("wea_single_cycle", {31'd0, prev_wea}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addra=%h dina=%h expected no write", addra, dina);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", {20'd0, addra}, {20'd0, e[27:16]});
                check("write_data", {16'd0, dina}, {16'd0, e[15:0]});
            end
            mem[addra[1:0]] = dina;
        end
        prev_wea = wea;
    end

    always @(negedge clka) begin : small_mon
        logic [17:0] e;
        if (s_wea) begin
            if (s_exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL small_unexpected_write: got addra=%h dina=%h expected no write", s_addra, s_dina);
            end else begin
                e = s_exp_q.pop_front();
                check("small_write_addr", {30'd0, s_addra}, {30'd0, e[17:16]});
                check("small_write_data", {16'd0, s_dina}, {16'd0, e[15:0]});
            end
        end
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rx_valid = 1'b0; rx_data = '0;
        s_start = 1'b0; s_abort = 1'b0; s_rx_valid = 1'b0; s_rx_data = '0;
        for (int i = 0; i < 4; i++) mem[i] = '0;

        vecs[0] = '{8'h12, 8'h34, 20, 12'd0, 16'h1234};
        vecs[1] = '{8'h56, 8'h78, 20, 12'd1, 16'h5678};
        vecs[2] = '{8'h9A, 8'hBC, 20, 12'd2, 16'h9ABC};
        vecs[3] = '{8'hDE, 8'hF0, 20, 12'd3, 16'hDEF0};
        vecs[4] = '{8'h0F, 8'hED, 0,  12'd0, 16'h0FED};
        vecs[5] = '{8'hCB, 8'hA9, 0,  12'd1, 16'hCBA9};
        vecs[6] = '{8'h87, 8'h65, 0,  12'd2, 16'h8765};
        vecs[7] = '{8'h43, 8'h21, 0,  12'd3, 16'h4321};

        step(3);
        check_idle_zero("reset");
        rst_n = 1'b1;
        step(1);

        // reset in the middle of a capture, after three bytes
        pulse_start();
        exp_q.push_back({12'd0, 16'h1122});
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        check("pre_reset_busy",  {31'd0, busy}, 32'd1);
        check("pre_reset_words", {19'd0, words_written}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_zero("async_reset");
        step(2);
        rst_n = 1'b1;
        step(3);
        send_byte(8'h55, 3);
        check("idle_ignores_rx_busy",  {31'd0, busy}, 32'd0);
        check("idle_ignores_rx_words", {19'd0, words_written}, 32'd0);

        // frame with 20-cycle byte spacing
        pulse_start();
        check("armed_busy", {31'd0, busy}, 32'd1);
        run_rows(0, 3);
        check("slow_done",  {31'd0, done}, 32'd1);
        check("slow_busy",  {31'd0, busy}, 32'd0);
        check("slow_words", {19'd0, words_written}, 32'd4);
        check("slow_addra_hold", {20'd0, addra}, 32'h3);
        check("slow_dina_hold",  {16'd0, dina}, 32'hDEF0);
        readback(0);

        // back-to-back bytes; done one cycle after the final write
        pulse_start();
        check("restart_clears_done", {31'd0, done}, 32'd0);
        run_rows(4, 7);
        @(negedge clka);
        check("last_wea_high", {31'd0, wea}, 32'd1);
        check("done_not_yet",  {31'd0, done}, 32'd0);
        @(negedge clka);
        check("done_after_wea", {31'd0, done}, 32'd1);
        check("wea_dropped",    {31'd0, wea}, 32'd0);
        step(1);
        check("fast_words", {19'd0, words_written}, 32'd4);
        readback(4);

        // abort keeps done; start+abort together stays idle
        pulse_abort();
        check("abort_keeps_done", {31'd0, done}, 32'd1);
        start = 1'b1;
        abort = 1'b1;
        step(1);
        start = 1'b0;
        abort = 1'b0;
        check("abort_wins_busy", {31'd0, busy}, 32'd0);
        check("abort_wins_done", {31'd0, done}, 32'd1);

        // mid-word timeout after 50 idle cycles
        pulse_start();
        send_byte(8'hAA, 0);
        rise = -1;
        for (int i = 1; i <= 60; i++) begin
            step(1);
            if (err_timeout && rise < 0) rise = i;
        end
        check("timeout_cycle", rise, 32'd50);
        check("timeout_busy",  {31'd0, busy}, 32'd0);
        check("timeout_words", {19'd0, words_written}, 32'd0);
        pulse_start();
        check("start_clears_err", {31'd0, err_timeout}, 32'd0);

        // low byte on the very cycle the timer would expire: the byte wins
        exp_q.push_back({12'd0, 16'h5AC3});
        send_byte(8'h5A, 49);
        send_byte(8'hC3, 1);
        check("receipt_wins_err",   {31'd0, err_timeout}, 32'd0);
        check("receipt_wins_words", {19'd0, words_written}, 32'd1);
        pulse_abort();
        check("abort_busy", {31'd0, busy}, 32'd0);

        // abort discards a partial word; start during a capture is ignored
        pulse_start();
        exp_q.push_back({12'd0, 16'h1122});
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        send_byte(8'h33, 0);
        pulse_abort();
        check("abort_partial_words", {19'd0, words_written}, 32'd1);
        pulse_start();
        exp_q.push_back({12'd0, 16'hA1B2});
        exp_q.push_back({12'd1, 16'hC3D4});
        exp_q.push_back({12'd2, 16'hE5F6});
        exp_q.push_back({12'd3, 16'h0718});
        send_byte(8'hA1, 0);
        send_byte(8'hB2, 0);
        send_byte(8'hC3, 0);
        pulse_start();
        send_byte(8'hD4, 0);
        send_byte(8'hE5, 0);
        send_byte(8'hF6, 0);
        send_byte(8'h07, 0);
        send_byte(8'h18, 2);
        check("restart_done",  {31'd0, done}, 32'd1);
        check("restart_words", {19'd0, words_written}, 32'd4);
        check("restart_mem0",  {16'd0, mem[0]}, 32'hA1B2);
        check("restart_mem3",  {16'd0, mem[3]}, 32'h0718);

        // timeout disabled: long mid-word gap on the 2-bit-address instance
        s_start = 1'b1;
        step(1);
        s_start = 1'b0;
        s_exp_q.push_back({2'd0, 16'h0102});
        s_exp_q.push_back({2'd1, 16'h0304});
        s_exp_q.push_back({2'd2, 16'h0506});
        s_exp_q.push_back({2'd3, 16'h0708});
        s_send_byte(8'h01, 2000);
        check("small_no_timeout", {31'd0, s_err_timeout}, 32'd0);
        check("small_still_busy", {31'd0, s_busy}, 32'd1);
        s_send_byte(8'h02, 0);
        s_send_byte(8'h03, 0);
        s_send_byte(8'h04, 0);
        s_send_byte(8'h05, 0);
        s_send_byte(8'h06, 0);
        s_send_byte(8'h07, 0);
        s_send_byte(8'h08, 2);
        check("small_words", {29'd0, s_words_written}, 32'd4);
        check("small_done",  {31'd0, s_done}, 32'd1);
        check("small_addra", {30'd0, s_addra}, 32'd3);

        step(2);
        check("main_exp_q_drained",  exp_q.size(), 32'd0);
        check("small_exp_q_drained", s_exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
